// File: rtl/ip_frag_tx.sv
// ip_frag_tx: cuts UDP datagrams into IP fragments with a 56-bit sideband.
// Optional IP_FRAG_TX_STAT_EN adds datagram/fragment counters and a length error pulse.
module ip_frag_tx #(
  parameter logic [15:0] P_MAX_FRAG_LEN = 16'd1480,
  parameter logic [7:0]  P_PROTOCOL     = 8'd17,
  parameter logic [15:0] P_ID_INIT      = 16'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] s_axis_udp_data,
  input  logic [15:0] s_axis_udp_user,
  input  logic [7:0]  s_axis_udp_keep,
  input  logic        s_axis_udp_last,
  input  logic        s_axis_udp_valid,
  output logic        s_axis_udp_ready,
  output logic [63:0] m_axis_ip_data,
  output logic [55:0] m_axis_ip_user,
  output logic [7:0]  m_axis_ip_keep,
  output logic        m_axis_ip_last,
  output logic        m_axis_ip_valid,
  input  logic        m_axis_ip_ready
`ifdef IP_FRAG_TX_STAT_EN
  ,
  output logic [31:0] o_dgram_cnt,
  output logic [31:0] o_frag_cnt,
  output logic        o_len_err
`endif
);

  localparam logic [12:0] LP_OFF_STEP = P_MAX_FRAG_LEN[15:3];
  localparam logic [2:0]  LP_DF       = 3'b010;
  localparam logic [2:0]  LP_MF       = 3'b001;
  localparam logic [2:0]  LP_NONE     = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_rem;
  logic [15:0] r_frag_len;
  logic [2:0]  r_flags;
  logic [12:0] r_off;
  logic [12:0] r_cnt;
  logic [15:0] r_id;
  logic [15:0] w_rem_nxt;
  logic [15:0] w_len_nxt;
  logic [2:0]  w_flags_nxt;
  logic [12:0] w_off_nxt;
  logic [12:0] w_cnt_nxt;
  logic [15:0] w_id_nxt;

  logic [63:0] r_data;
  logic [55:0] r_user;
  logic [7:0]  r_keep;
  logic        r_last;
  logic        r_valid;

  logic [15:0] w_cur_rem;
  logic [15:0] w_cur_len;
  logic [2:0]  w_cur_flags;
  logic [12:0] w_cur_off;
  logic [12:0] w_cur_cnt;
  logic [16:0] w_nb;
  logic        w_cnt_end;
  logic        w_fend;
  logic [15:0] w_rem_left;
  logic [15:0] w_len_left;
  logic [2:0]  w_flags_left;
  logic        w_s_ready;
  logic        w_acc;
  logic        w_load;

  assign w_s_ready = (r_state == S_DROP) | m_axis_ip_ready | ~r_valid;
  assign w_acc     = s_axis_udp_valid & w_s_ready;
  assign w_load    = w_acc & (r_state != S_DROP);

  // Fragment context of the beat on the input: fresh from the length in IDLE.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_cur_rem   = s_axis_udp_user;
      w_cur_len   = (s_axis_udp_user > P_MAX_FRAG_LEN) ?
                    P_MAX_FRAG_LEN : s_axis_udp_user;
      w_cur_flags = (s_axis_udp_user > P_MAX_FRAG_LEN) ? LP_MF : LP_DF;
      w_cur_off   = '0;
      w_cur_cnt   = '0;
    end else begin
      w_cur_rem   = r_rem;
      w_cur_len   = r_frag_len;
      w_cur_flags = r_flags;
      w_cur_off   = r_off;
      w_cur_cnt   = r_cnt;
    end
  end

  assign w_nb         = ({1'b0, w_cur_len} + 17'd7) >> 3;
  assign w_cnt_end    = ({4'b0, w_cur_cnt} == (w_nb - 17'd1));
  assign w_fend       = w_cnt_end | s_axis_udp_last;
  assign w_rem_left   = w_cur_rem - w_cur_len;
  assign w_len_left   = (w_rem_left > P_MAX_FRAG_LEN) ?
                        P_MAX_FRAG_LEN : w_rem_left;
  assign w_flags_left = (w_rem_left > P_MAX_FRAG_LEN) ? LP_MF : LP_NONE;

  // Next state and fragment bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_len_nxt   = r_frag_len;
    w_flags_nxt = r_flags;
    w_off_nxt   = r_off;
    w_cnt_nxt   = r_cnt;
    w_id_nxt    = r_id;
    unique case (r_state)
      S_IDLE, S_SEND: begin
        if (w_acc) begin
          if (s_axis_udp_last) begin
            w_state_nxt = S_IDLE;
            w_id_nxt    = r_id + 16'd1;
          end else if (w_cnt_end) begin
            if (w_rem_left == 16'd0) begin
              w_state_nxt = S_DROP;
            end else begin
              w_state_nxt = S_SEND;
              w_rem_nxt   = w_rem_left;
              w_len_nxt   = w_len_left;
              w_flags_nxt = w_flags_left;
              w_off_nxt   = w_cur_off + LP_OFF_STEP;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_state_nxt = S_SEND;
            w_rem_nxt   = w_cur_rem;
            w_len_nxt   = w_cur_len;
            w_flags_nxt = w_cur_flags;
            w_off_nxt   = w_cur_off;
            w_cnt_nxt   = w_cur_cnt + 13'd1;
          end
        end
      end
      S_DROP: begin
        if (w_acc && s_axis_udp_last) begin
          w_state_nxt = S_IDLE;
          w_id_nxt    = r_id + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and fragment context registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_frag_len <= '0;
      r_flags    <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
      r_id       <= P_ID_INIT;
    end else begin
      r_state    <= w_state_nxt;
      r_rem      <= w_rem_nxt;
      r_frag_len <= w_len_nxt;
      r_flags    <= w_flags_nxt;
      r_off      <= w_off_nxt;
      r_cnt      <= w_cnt_nxt;
      r_id       <= w_id_nxt;
    end
  end

  // Single output register stage; valid holds until taken.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_data  <= '0;
      r_user  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= s_axis_udp_data;
      r_user  <= {w_cur_len, w_cur_flags, P_PROTOCOL, w_cur_off, r_id};
      r_keep  <= s_axis_udp_last ? s_axis_udp_keep : 8'hFF;
      r_last  <= w_fend;
      r_valid <= 1'b1;
    end else if (m_axis_ip_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign s_axis_udp_ready = w_s_ready;
  assign m_axis_ip_data   = r_data;
  assign m_axis_ip_user   = r_user;
  assign m_axis_ip_keep   = r_keep;
  assign m_axis_ip_last   = r_last;
  assign m_axis_ip_valid  = r_valid;

`ifdef IP_FRAG_TX_STAT_EN
  logic        w_final;
  logic        w_early;
  logic        w_len_err;
  logic [31:0] r_dgram_cnt;
  logic [31:0] r_frag_cnt;
  logic        r_len_err;

  assign w_final   = (w_cur_rem == w_cur_len);
  assign w_early   = s_axis_udp_last & ~(w_cnt_end & w_final);
  assign w_len_err = w_acc & ((r_state == S_DROP) | w_early);

  // Statistics: completed datagrams, emitted fragments, length errors.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_dgram_cnt <= '0;
      r_frag_cnt  <= '0;
      r_len_err   <= 1'b0;
    end else begin
      if (w_acc && s_axis_udp_last)
        r_dgram_cnt <= r_dgram_cnt + 32'd1;
      if (r_valid && r_last && m_axis_ip_ready)
        r_frag_cnt <= r_frag_cnt + 32'd1;
      r_len_err <= w_len_err;
    end
  end

  assign o_dgram_cnt = r_dgram_cnt;
  assign o_frag_cnt  = r_frag_cnt;
  assign o_len_err   = r_len_err;
`endif

endmodule

// File: doc/ip_frag_tx.md
Name: ip_frag_tx

Overview:
- TX-side IP fragmenter placed between UDP_TX and the IP transmit layer.
- Takes one complete UDP datagram per packet on a 64-bit AXI-Stream, with the UDP header in the first beat.
- Cuts the datagram into IP fragments of at most P_MAX_FRAG_LEN payload bytes.
- Emits each fragment with the 56-bit IP sideband {len16, flags3, proto8, offset13, id16} that the UDP_RX receive path consumes.

Parameters:
- P_MAX_FRAG_LEN, 16'd1480: maximum fragment payload in bytes. Must be a multiple of 8, so fragment cuts always fall on beat boundaries.
- P_PROTOCOL, 8'd17: value driven in the proto field.
- P_ID_INIT, 16'd0: identification value loaded at reset.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- s_axis_udp_data  in  64  datagram bytes; byte 0 is in [63:56].
- s_axis_udp_user  in  16  datagram byte length, UDP header included. Sampled on the first beat only.
- s_axis_udp_keep  in  8  byte enables; meaningful on the last beat only.
- s_axis_udp_last  in  1  end of datagram.
- s_axis_udp_valid  in  1  input valid.
- s_axis_udp_ready  out  1  input ready.
- m_axis_ip_data  out  64  fragment data.
- m_axis_ip_user  out  56  {frag_len16, flags3, proto8, offset13, id16}; constant for the whole fragment.
- m_axis_ip_keep  out  8  byte enables.
- m_axis_ip_last  out  1  end of fragment.
- m_axis_ip_valid  out  1  output valid.
- m_axis_ip_ready  in  1  output ready.

Behaviour:
- Reset: i_rst low asynchronously clears every output to 0, sets state to IDLE, and loads the id counter with P_ID_INIT. Reset mid-datagram abandons the datagram; no partial fragment resumes after release.
- Datapath: single output register stage, latency 1 cycle.
  - s_axis_udp_ready = m_axis_ip_ready | ~m_axis_ip_valid.
  - The output register loads on s_valid & s_ready.
  - m_valid drops only when the output beat is taken and no new beat loads.
- State IDLE: waits for the first input beat.
  - Sets rem = user length and offset = 0.
  - Sets frag_len = min(rem, P_MAX_FRAG_LEN) and beat_cnt = 0.
  - Sets flags:
    - 3'b010 (DF) if rem <= P_MAX_FRAG_LEN;
    - otherwise 3'b001 (MF).
  - Forwards the beat and goes to SEND. A single-beat datagram (last on the first beat) stays in IDLE.
- State SEND: forwards each accepted beat and increments beat_cnt.
  - Fragment end: beat_cnt == ceil(frag_len/8) - 1, or input last.
  - On a fragment end, the output beat has last = 1.
  - Output keep on a fragment end: 8'hFF on an intermediate fragment end; the input keep on the datagram's final beat.
- Boundary, next fragment (fragment end without input last):
  - rem -= frag_len; offset += P_MAX_FRAG_LEN/8.
  - The next frag_len and flags are computed in the same cycle, so there is no bubble between fragments.
  - Flags are 3'b001 while rem > P_MAX_FRAG_LEN, and 3'b000 for the final fragment.
- Boundary, datagram end (input last accepted): id increments by 1 (wraps 16'hFFFF -> 0) and state returns to IDLE.
- Early input last (before the length is exhausted): the beat is marked last; the sideband already issued is unchanged; length error.
- Excess beats (rem is exhausted but input last has not arrived): beats are accepted with ready = 1 and dropped, not forwarded, until input last; length error.
- Fragment offsets are always in 8-byte units. frag_len counts IP payload bytes and excludes the IP header.

Optional Feature:
- Macro: IP_FRAG_TX_STAT_EN.
- When defined, adds three outputs:
  - o_dgram_cnt[31:0]: datagrams completed.
  - o_frag_cnt[31:0]: fragments emitted, counted on m last & valid & ready.
  - o_len_err: one-cycle pulse on every early-last or excess-beat event.
  - All three clear on reset; both counters wrap.
- When not defined, these ports and their logic are absent. Length errors are then handled silently as described in Behaviour.

Test Plan:
- 1480-byte datagram, m_ready = 1 -> one fragment of 185 beats; user {1480, 3'b010, 17, 0, id 0}; last on beat 185; keep 8'hFF.
- 3472-byte datagram -> three fragments with no gaps between them:
  - user {1480, 001, 17, 0, 1}, 185 beats;
  - user {1480, 001, 17, 185, 1}, 185 beats;
  - user {512, 000, 17, 370, 1}, 64 beats.
- 1485-byte datagram, final input keep 8'hF8 -> fragments:
  - {1480, 001, 17, 0, id}, 185 beats;
  - {5, 000, 17, 185, id}, 1 beat with keep 8'hF8.
- Rerun the 3472-byte case with m_ready low for 3 cycles after every m last:
  - data is identical to the m_ready = 1 run;
  - s_ready is low whenever the output register is full and m_ready is low;
  - no beat is lost or duplicated.
- Length 1480 with input last at beat 100 -> fragment ends at beat 100 with last = 1; o_len_err pulses once; the next datagram gets id + 1.
- Drive i_rst low at beat 50 of a 3472-byte datagram, then send a 512-byte datagram -> after reset, user {512, 010, 17, 0, P_ID_INIT}; no stale beats appear.
